// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads words from instruction memory over req/ack and holds them in the IR until Control takes them.
// Optional HALT on opcode 4'b1111 is compiled in when IFETCH_HALT_EN is defined.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
`ifdef IFETCH_HALT_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_pc;

    // Handshakes: memory read completes on a cycle with mem_req && mem_ack (ack ignored otherwise);
    // the IR transfers to Control on a cycle with ir_valid && ir_ready, and redirect overrides that transfer.
    assign mem_req   = (state == S_FETCH) || (state == S_DRAIN);
    assign mem_addr  = fetch_pc;
    assign ir_valid  = (state == S_HOLD);
    assign opcode    = ir[INSTR_W-1 -: 4];
    assign dbg_state = state;

`ifdef IFETCH_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            ir       <= '0;
            ir_pc    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        if (redirect) begin
                            fetch_pc <= redirect_pc;
                        end else begin
                            ir       <= mem_rdata;
                            ir_pc    <= fetch_pc;
                            fetch_pc <= fetch_pc + ADDR_W'(1);
                            state    <= S_HOLD;
                        end
                    end else if (redirect) begin
                        // The in-flight read must finish at its original address before retargeting.
                        pend_pc <= redirect_pc;
                        state   <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        state    <= S_FETCH;
                    end else if (ir_ready) begin
`ifdef IFETCH_HALT_EN
                        state <= (opcode == 4'b1111) ? S_HALT : S_FETCH;
`else
                        state <= S_FETCH;
`endif
                    end
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        fetch_pc <= redirect ? redirect_pc : pend_pc;
                        state    <= S_FETCH;
                    end else if (redirect) begin
                        pend_pc <= redirect_pc;
                    end
                end
`ifdef IFETCH_HALT_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random-latency memory and random Control traffic against an
// architectural next-PC model; directed cases cover reset, hold, redirects, wrap and HALT.
module tb_instr_fetch;
    localparam int AW = 16;
    localparam int IW = 16;
    localparam logic [AW-1:0] RST_PC = 16'h0000;

    logic          clk;
    logic          rst_n;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic [IW-1:0] ir;
    logic [3:0]    opcode;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halted;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected address of the next instruction to be delivered to Control.
    logic [AW-1:0] exp_q[$];

    int  mem_wait  = 0;
    bit  rand_mode = 0;

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .opcode(opcode), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] t;
        logic [IW-1:0] w;
        if (a == 16'h0000) return 16'h4123;
        if (a == 16'h0300) return 16'hF000;
        t = {16'h0, a} * 32'h9E37;
        w = t[15:0] ^ 16'h1D2B;
        if (w[15:12] == 4'hF) w[15] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (ir_valid) return;
        end
        chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] target, input logic rdy);
        step();
        redirect    = 1'b1;
        redirect_pc = target;
        ir_ready    = rdy;
        step();
        redirect = 1'b0;
        ir_ready = 1'b0;
    endtask

    // ---------------- memory driver ----------------
    initial begin
        bit in_req;
        int cnt;
        in_req = 0;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            step();
            if (rst_n !== 1'b1) begin
                in_req = 0;
                mem_ack = 1'b0;
            end else begin
                if (mem_ack) in_req = 0;
                if (mem_req) begin
                    if (!in_req) begin
                        in_req = 1;
                        cnt = rand_mode ? int'($urandom_range(0, 3)) : mem_wait;
                    end
                    if (cnt == 0) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_word(mem_addr);
                    end else begin
                        cnt--;
                        mem_ack = 1'b0;
                        mem_rdata = 16'($urandom);
                    end
                end else begin
                    in_req = 0;
                    mem_ack = ($urandom_range(0, 3) == 0);
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit            stale;
        bit            addr_chk;
        bit            exp_latch;
        bit            model_halted;
        bit            prev_wait;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] p;
        logic [IW-1:0] w;
        stale = 0; addr_chk = 0; exp_latch = 0; model_halted = 0; prev_wait = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                chk("reset_outputs", {27'd0, mem_req, ir_valid, opcode == 4'd0, halted, 1'b0},
                    {27'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
                chk("reset_addr", {16'd0, mem_addr}, {16'd0, RST_PC});
                exp_q.delete();
                exp_q.push_back(RST_PC);
                stale = 0; addr_chk = 1; exp_latch = 0; model_halted = 0; prev_wait = 0;
            end else if (model_halted) begin
                chk("halt_state", {29'd0, halted, mem_req, ir_valid}, {29'd0, 3'b100});
                prev_wait = 0;
            end else begin
                if (prev_wait) chk("addr_stable", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, prev_addr});
                if (addr_chk) begin
                    chk("next_fetch_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, exp_q[0]});
                    addr_chk = 0;
                end
                if (exp_latch) begin
                    chk("latch_latency", {31'd0, ir_valid}, 32'd1);
                    exp_latch = 0;
                end
                chk("req_vs_valid", {30'd0, halted, mem_req ^ ir_valid}, {30'd0, 2'b01});
                if (ir_valid) begin
                    w = mem_word(exp_q[0]);
                    chk("hold_ir", {ir_pc, ir}, {exp_q[0], w});
                    chk("hold_opcode", {28'd0, opcode}, {28'd0, w[15:12]});
                end
                prev_wait = mem_req && !mem_ack;
                prev_addr = mem_addr;
                if (redirect) begin
                    if (ir_valid || (mem_req && mem_ack)) addr_chk = 1;
                    stale = mem_req && !mem_ack;
                    exp_q.delete();
                    exp_q.push_back(redirect_pc);
                end else if (mem_req && mem_ack) begin
                    if (stale) begin
                        stale = 0;
                        addr_chk = 1;
                    end else begin
                        chk("fetch_addr", {16'd0, mem_addr}, {16'd0, exp_q[0]});
                        exp_latch = 1;
                    end
                end else if (ir_valid && ir_ready) begin
                    p = exp_q.pop_front();
                    chk("consume_pc", {16'd0, ir_pc}, {16'd0, p});
                    w = mem_word(p);
`ifdef IFETCH_HALT_EN
                    if (w[15:12] == 4'hF) begin
                        model_halted = 1;
                    end else begin
                        exp_q.push_back(p + 16'd1);
                        addr_chk = 1;
                    end
`else
                    exp_q.push_back(p + 16'd1);
                    addr_chk = 1;
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        ir_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // First fetch after reset
        wait_valid(20);
        chk("tp_first_opcode", {28'd0, opcode}, 32'h4);
        chk("tp_first_ir", {16'd0, ir_pc, ir}, {16'd0, 16'h0000, 16'h4123});

        // Stall in HOLD, then accept
        repeat (5) step();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;

        // Redirect in HOLD with simultaneous accept
        wait_valid(20);
        pulse_redirect(16'h0040, 1'b1);
        wait_valid(20);
        chk("tp_redirect_hold", {16'd0, ir_pc}, 32'h0040);

        // Redirect while a slow fetch at 0x0005 is outstanding
        mem_wait = 3;
        pulse_redirect(16'h0005, 1'b0);
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        step();
        redirect = 1'b0;
        wait_valid(40);
        chk("tp_drain_target", {16'd0, ir_pc}, 32'h0080);
        mem_wait = 0;

        // Address wrap
        pulse_redirect(16'hFFFF, 1'b0);
        wait_valid(20);
        chk("tp_wrap_pc", {16'd0, ir_pc}, 32'hFFFF);
        step();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        @(negedge clk);
        chk("tp_wrap_next", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});

        // Randomized traffic with one mid-run reset
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            ir_ready = ($urandom_range(0, 2) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom_range(16'h1000, 16'hFFFF));
        end
        step();
        redirect = 1'b0;
        ir_ready = 1'b0;
        rand_mode = 0;

`ifdef IFETCH_HALT_EN
        wait_valid(20);
        pulse_redirect(16'h0300, 1'b0);
        wait_valid(20);
        chk("tp_halt_opcode", {28'd0, opcode}, 32'hF);
        step();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        repeat (4) step();
        pulse_redirect(16'h1234, 1'b0);
        repeat (4) step();
        @(negedge clk);
        chk("tp_halt_sticky", {30'd0, halted, mem_req}, 32'b10);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("tp_halt_reset", {14'd0, halted, mem_req, mem_addr}, {14'd0, 1'b0, 1'b1, RST_PC});
        wait_valid(20);
`endif

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
